// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: the I-cache (port 0) and D-cache (port 1) controllers
// share one memory port. A single transaction is in flight at a time and
// contention is settled by a round-robin pointer.
//
// Handshake: a requester raises rq_valid[i] with its rw/addr/wdata and holds
// them until rq_ready[i] pulses for one cycle. It drops rq_valid in the cycle
// after that pulse. On the memory side, mem_valid stays high with stable
// fields until mem_ready pulses, and mem_rdata is valid in that same cycle.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        rq_valid,
  input  logic [1:0]        rq_rw,
  input  logic [ADDR_W-1:0] rq_addr0,
  input  logic [ADDR_W-1:0] rq_addr1,
  input  logic [DATA_W-1:0] rq_wdata0,
  input  logic [DATA_W-1:0] rq_wdata1,
  output logic [1:0]        rq_ready,
  output logic [DATA_W-1:0] rq_rdata,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       ptr;
  logic       grant_any;
  logic       grant_idx;

  // Pick the winner: a lone requester wins outright, a tie goes to the pointer.
  always_comb begin
    grant_any = |rq_valid;
    grant_idx = 1'b0;
    case (rq_valid)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ptr;
      default: grant_idx = 1'b0;
    endcase
  end

  // Next-state logic; mem_ready only matters while a memory access is open.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = BUSY;
      BUSY:    if (mem_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any open transaction without a ready pulse.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant bookkeeping and the latched memory request fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 1'b0;
      owner     <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE && grant_any) begin
      owner     <= grant_idx;
      ptr       <= ~grant_idx;
      mem_rw    <= grant_idx ? rq_rw[1]  : rq_rw[0];
      mem_addr  <= grant_idx ? rq_addr1  : rq_addr0;
      mem_wdata <= grant_idx ? rq_wdata1 : rq_wdata0;
    end
  end

  // Capture memory read data on completion; writes load it too and the
  // requester simply ignores it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rq_rdata <= '0;
    end else if (state == BUSY && mem_ready) begin
      rq_rdata <= mem_rdata;
    end
  end

  // Outputs decoded from state: one-hot ready only in DONE, request valid only in BUSY.
  always_comb begin
    rq_ready  = 2'b00;
    if (state == DONE) rq_ready[owner] = 1'b1;
    mem_valid = (state == BUSY);
    busy      = (state != IDLE);
    state_dbg = state;
  end

endmodule
